// File: rtl/fir_filter_gd_pkg.sv
// Shared types and constants for the gradient-descent FIR feeder and its
// stage-register instantiation.
package fir_filter_gd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } gd_feed_state_t;

  localparam int INPUT_WIDTH_DEF  = 32;
  localparam int NUM_TAPS_DEF     = 8;
  localparam int DRAIN_CYCLES_DEF = 4;

  // Counter/index width; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fir_filter_gd_feeder_if.sv
// Handshake and stage-register bundle between the upstream sequencer source
// (master) and the fir_filter_gd feeder (slave).
interface fir_filter_gd_feeder_if
  import fir_filter_gd_pkg::*;
#(
  parameter int INPUT_WIDTH = INPUT_WIDTH_DEF,
  parameter int NUM_TAPS    = NUM_TAPS_DEF
);
  localparam int IDX_W = idx_w(NUM_TAPS);

  logic [INPUT_WIDTH-1:0] sample_in;
  logic                   sample_valid_in;
  logic                   sample_ready_out;
  logic [INPUT_WIDTH-1:0] coeff_in;
  logic                   coeff_valid_in;
  logic                   coeff_ready_out;
  logic                   stall_in;
  logic                   abort_in;
  logic [INPUT_WIDTH-1:0] fir_input_out;
  logic [INPUT_WIDTH-1:0] coeff_data_out;
  logic [IDX_W-1:0]       coeff_index_out;
  logic                   overwrite_out;
  logic                   output_valid_out;
  logic                   freeze_out;
  logic                   flush_out;
  logic                   busy_out;

  modport master (
    output sample_in, sample_valid_in, coeff_in, coeff_valid_in, stall_in, abort_in,
    input  sample_ready_out, coeff_ready_out, fir_input_out, coeff_data_out,
           coeff_index_out, overwrite_out, output_valid_out, freeze_out, flush_out,
           busy_out
  );

  modport slave (
    input  sample_in, sample_valid_in, coeff_in, coeff_valid_in, stall_in, abort_in,
    output sample_ready_out, coeff_ready_out, fir_input_out, coeff_data_out,
           coeff_index_out, overwrite_out, output_valid_out, freeze_out, flush_out,
           busy_out
  );

endinterface

// File: rtl/fir_filter_gd_tap_counter.sv
// Wrap-at-N counter with clear and enable; tc flags the last count value.
module fir_filter_gd_tap_counter
  import fir_filter_gd_pkg::*;
#(
  parameter int N = NUM_TAPS_DEF,
  parameter int W = idx_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/fir_filter_gd_feeder.sv
// Writer side of the fir_filter_gd stage registers: serialises samples and
// coefficient bursts, with a drain window after every burst.
module fir_filter_gd_feeder
  import fir_filter_gd_pkg::*;
#(
  parameter int INPUT_WIDTH  = INPUT_WIDTH_DEF,
  parameter int NUM_TAPS     = NUM_TAPS_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  fir_filter_gd_feeder_if.slave bus
);

  localparam int IDX_W = idx_w(NUM_TAPS);
  localparam int DRN_W = idx_w(DRAIN_CYCLES);

  gd_feed_state_t state;

  logic             go;
  logic             sample_acc;
  logic             coeff_acc;
  logic [IDX_W-1:0] tap_cnt;
  logic             tap_tc;
  logic [DRN_W-1:0] drain_cnt;
  logic             drain_tc;

  logic signed [INPUT_WIDTH-1:0] fir_input_p1;
  logic signed [INPUT_WIDTH-1:0] coeff_data_p1;
  logic [IDX_W-1:0]              coeff_index_p1;
  logic                          overwrite_p1;
  logic                          output_valid_p1;
  logic                          busy_p1;

  // Readies depend only on state/stall/abort, plus coeff-over-sample in IDLE.
  assign go                   = !bus.abort_in && !bus.stall_in;
  assign bus.coeff_ready_out  = go && (state != DRAIN);
  assign bus.sample_ready_out = go && (state == IDLE) && !bus.coeff_valid_in;
  assign coeff_acc            = bus.coeff_valid_in && bus.coeff_ready_out;
  assign sample_acc           = bus.sample_valid_in && bus.sample_ready_out;
  assign bus.freeze_out       = bus.stall_in;
  assign bus.flush_out        = bus.abort_in;

  fir_filter_gd_tap_counter #(.N(NUM_TAPS), .W(IDX_W)) u_tap_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.abort_in),
    .en  (coeff_acc),
    .cnt (tap_cnt),
    .tc  (tap_tc)
  );

  fir_filter_gd_tap_counter #(.N(DRAIN_CYCLES), .W(DRN_W)) u_drain_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.abort_in),
    .en  (go && (state == DRAIN)),
    .cnt (drain_cnt),
    .tc  (drain_tc)
  );

  // p1: stage-register bundle, one cycle after the handshake
  always_ff @(posedge clk) begin
    if (rst || bus.abort_in) begin
      state           <= IDLE;
      fir_input_p1    <= '0;
      coeff_data_p1   <= '0;
      coeff_index_p1  <= '0;
      overwrite_p1    <= 1'b0;
      output_valid_p1 <= 1'b0;
      busy_p1         <= 1'b0;
    end else if (!bus.stall_in) begin
      overwrite_p1    <= coeff_acc;
      output_valid_p1 <= sample_acc;
      busy_p1         <= (state != IDLE) || coeff_acc;
      if (sample_acc) begin
        fir_input_p1 <= bus.sample_in;
      end
      if (coeff_acc) begin
        coeff_data_p1  <= bus.coeff_in;
        coeff_index_p1 <= tap_cnt;
      end
      case (state)
        IDLE:    if (coeff_acc) state <= LOAD;
        LOAD:    if (coeff_acc && tap_tc) state <= DRAIN;
        DRAIN:   if (drain_tc) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.fir_input_out    = fir_input_p1;
  assign bus.coeff_data_out   = coeff_data_p1;
  assign bus.coeff_index_out  = coeff_index_p1;
  assign bus.overwrite_out    = overwrite_p1;
  assign bus.output_valid_out = output_valid_p1;
  assign bus.busy_out         = busy_p1;

endmodule

// File: doc/fir_filter_gd_feeder.md
# fir_filter_gd_feeder

Upstream sequencer for the gradient-descent FIR pipeline: the writer side of the `fir_filter_gd` stage registers. It accepts input samples and coefficient-update bursts over valid/ready handshakes. It serialises them into the stage-register input bundle (`fir_input`, `coeff_data`, `overwrite`, `output_valid`) and generates the pipeline-wide `freeze` and `flush` controls. A drain window after every coefficient burst keeps samples from meeting a half-updated tap set.

## Interface
- `INPUT_WIDTH`, 32, width of samples and coefficient words
- `NUM_TAPS`, 8, coefficient words per update burst (≥2)
- `DRAIN_CYCLES`, 4, bubble cycles after a burst (≥1); equals pipeline depth
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `sample_in` in INPUT_WIDTH: input sample
- `sample_valid_in` in 1: sample offered
- `sample_ready_out` out 1: sample accepted when valid&ready
- `coeff_in` in INPUT_WIDTH: coefficient word
- `coeff_valid_in` in 1: coefficient offered
- `coeff_ready_out` out 1: coefficient accepted when valid&ready
- `stall_in` in 1: downstream backpressure
- `abort_in` in 1: discard in-flight work
- `fir_input_out` out INPUT_WIDTH: to stage register `fir_input_in`
- `coeff_data_out` out INPUT_WIDTH: to stage register `coeff_data_in`
- `coeff_index_out` out clog2(NUM_TAPS): tap address of `coeff_data_out`
- `overwrite_out` out 1: coefficient write strobe
- `output_valid_out` out 1: sample-valid strobe
- `freeze_out` out 1: pipeline freeze
- `flush_out` out 1: pipeline flush
- `busy_out` out 1: high in LOAD or DRAIN

## Operation
- Priority per cycle: `rst` > `abort_in` > `stall_in` > handshakes.
- States:
  - IDLE: `sample_ready_out` = 1 and `coeff_ready_out` = 1.
    - Coefficient handshake: go to LOAD, with index 0 consumed.
    - Simultaneous sample and coeff valid: coeff wins; `sample_ready_out` is forced 0 that cycle.
  - LOAD: `coeff_ready_out` = 1, `sample_ready_out` = 0. Each accepted word increments the tap index. The word with index NUM_TAPS-1 moves the block to DRAIN and clears the index. Gaps in `coeff_valid_in` are allowed: the state holds and the strobes are 0.
  - DRAIN: both readies 0. The counter runs DRAIN_CYCLES cycles, then the block returns to IDLE.
- Accepted sample: next cycle `fir_input_out` = sample, `output_valid_out` = 1, `overwrite_out` = 0.
- Accepted coefficient: next cycle `coeff_data_out` = word, `coeff_index_out` = index, `overwrite_out` = 1, `output_valid_out` = 0.
- No handshake in a cycle: both strobes go to 0 next cycle. Data outputs hold their last value.
- `freeze_out` = `stall_in`, combinational. While stalled:
  - both readies are 0;
  - all registers, state and counters hold;
  - strobes hold, mirroring the frozen stage register.
- `flush_out` = `abort_in`, combinational. On abort:
  - next edge goes to IDLE;
  - counters and all registered outputs go to 0;
  - any partial burst is discarded (tap set is undefined; software reloads);
  - both readies are 0 in the abort cycle.
- `busy_out` is registered and decoded from state.

## Timing
- Reset (synchronous): state IDLE, counters 0, all registered outputs 0.
- Out of reset, readies are 1 once `rst` is low.
- Handshake-to-output latency: 1 cycle.
- Throughput: 1 sample per cycle in IDLE with no stall.
- Burst cost: NUM_TAPS accept cycles minimum, plus DRAIN_CYCLES cycles.
  - First sample accept: cycle NUM_TAPS+DRAIN_CYCLES after the first coeff accept (cycle 0).
- Readies are combinational from state, `stall_in` and `abort_in`; no dependency on the valids, except the coeff-over-sample rule in IDLE.
- Stall during DRAIN: the drain counter freezes, so bubble count is preserved.
- Stall on the last LOAD beat: no accept, so no DRAIN entry.
- `rst` mid-burst is identical to abort, except `flush_out` is not asserted.

## Structure
- Package `fir_filter_gd_pkg` holds:
  - the state enum `gd_feed_state_t` {IDLE, LOAD, DRAIN};
  - the index width function;
  - the default NUM_TAPS/DRAIN_CYCLES constants shared with the stage-register instantiation.
- Sub-module `fir_filter_gd_tap_counter`: a wrap-at-N counter with `en`/`clr` and a terminal-count flag. It is instantiated twice, for the tap index and the drain count.

## Test plan
- Reset, then samples 0x11, 0x22, 0x33 back-to-back:
  - `fir_input_out` shows 0x11/0x22/0x33 on cycles 1/2/3 with `output_valid_out` = 1;
  - `overwrite_out` = 0;
  - `output_valid_out` falls on cycle 4.
- Burst of 8 coeffs 0xA0..0xA7, NUM_TAPS=8, DRAIN_CYCLES=4:
  - `coeff_index_out` = 0..7 with `overwrite_out` = 1;
  - `sample_ready_out` = 0 for cycles 0–11;
  - `sample_ready_out` = 1 at cycle 12 (first sample accept);
  - `busy_out` = 1 for cycles 1–12.
- Sample and coeff valid together in IDLE: coeff accepted, sample held. The sample is accepted only after the burst and drain complete.
- `stall_in` for 3 cycles mid-burst at index 3:
  - `freeze_out` = 1 for those 3 cycles;
  - outputs are frozen at index 3;
  - the burst resumes at index 4, and no word is lost or duplicated.
- `abort_in` at index 5:
  - `flush_out` pulses 1 cycle;
  - next cycle state is IDLE, `busy_out` = 0, all outputs 0;
  - a new burst starts at index 0.
- `rst` asserted during DRAIN with `stall_in` high: after one edge, all outputs are 0 and state is IDLE.
